seg_scan_decoder: RTL and testbench



---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_pattern_lookup.sv | 21 ++
 rtl/seg_scan_decoder.sv | 133 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan path: bus layout, glyph table, FSM states.
package seg_pkg;

    localparam int SEG_W  = 8;
    localparam int SEG_DP = 0;
    localparam int SEG_G  = 1;
    localparam int SEG_A  = 7;
    localparam int NPAT   = 16;

    // Entry n is the a..g pattern (a in the MSB) that displays hex digit n.
    localparam logic [NPAT-1:0][6:0] SEG_TABLE = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b0001101,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0000110, 7'b1111110
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HELD
    } state_t;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Reverse glyph lookup: a..g pattern to hex nibble, with a hit flag for unknown glyphs.
module seg_pattern_lookup
    import seg_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'h0;
        for (int k = 0; k < NPAT; k++) begin
            if (i_pat == SEG_TABLE[k]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reads a multiplexed 7-segment scan bus, captures each stable digit dwell once
// and publishes a complete NDIG-digit word when every digit has been seen.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEG_W-1:0]    seg_i,
    input  logic [NDIG-1:0]     an_i,
    output logic [4*NDIG-1:0]   value_o,
    output logic [NDIG-1:0]     dp_o,
    output logic [NDIG-1:0]     bad_mask_o,
    output logic                frame_valid_o,
    output logic                sel_err_o
);

    localparam int              CNT_W    = $clog2(STABLE_CYC + 1);
    localparam int              SAMP_W   = NDIG + SEG_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    logic [SAMP_W-1:0]  r_samp_p0;
    logic [SAMP_W-1:0]  r_prev_p1;
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NDIG-1:0]    r_seen;
    logic [NDIG-1:0]    r_bad;
    logic [NDIG-1:0]    r_dp_buf;
    logic [4*NDIG-1:0]  r_nib_buf;

    logic [NDIG-1:0]    w_an;
    logic [SEG_W-1:0]   w_seg;
    logic               w_same;
    logic               w_eval;
    logic               w_onehot;
    logic               w_sel_err;
    logic               w_cap;
    logic               w_done;
    logic               w_hit;
    logic [3:0]         w_nib;

    assign w_an      = r_samp_p0[SAMP_W-1:SEG_W];
    assign w_seg     = r_samp_p0[SEG_W-1:0];
    assign w_same    = (r_samp_p0 == r_prev_p1);
    // The edge that moves the counter onto STABLE_CYC is the single evaluation point of a dwell.
    assign w_eval    = (r_state == WAIT) && w_same && (r_cnt == CNT_LAST);
    assign w_onehot  = $onehot(w_an);
    assign w_sel_err = w_eval && !w_onehot && (w_an != '0);
    assign w_cap     = w_eval && w_onehot;
    assign w_done    = &r_seen;

    seg_pattern_lookup u_lookup (
        .i_pat    (w_seg[SEG_A:SEG_G]),
        .o_hit    (w_hit),
        .o_nibble (w_nib)
    );

    // Stage p0/p1: input sample, previous sample and dwell tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_samp_p0 <= '0;
            r_prev_p1 <= '0;
            r_state   <= IDLE;
            r_cnt     <= '0;
        end else begin
            r_samp_p0 <= {an_i, seg_i};
            r_prev_p1 <= r_samp_p0;
            case (r_state)
                IDLE: begin
                    if (!w_same) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!w_same) begin
                        r_cnt <= CNT_ONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!w_same) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= WAIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stage p2: digit capture buffers and frame publication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen        <= '0;
            r_bad         <= '0;
            r_dp_buf      <= '0;
            r_nib_buf     <= '0;
            value_o       <= '0;
            dp_o          <= '0;
            bad_mask_o    <= '0;
            frame_valid_o <= 1'b0;
            sel_err_o     <= 1'b0;
        end else begin
            frame_valid_o <= w_done;
            sel_err_o     <= w_sel_err;
            if (w_done) begin
                value_o    <= r_nib_buf;
                dp_o       <= r_dp_buf;
                bad_mask_o <= r_bad;
                r_seen     <= '0;
                r_bad      <= '0;
            end
            // Placed after the clear so a capture on the completion edge opens the next frame.
            for (int i = 0; i < NDIG; i++) begin
                if (w_cap && w_an[i]) begin
                    r_nib_buf[4*i +: 4] <= w_nib;
                    r_dp_buf[i]         <= w_seg[SEG_DP];
                    r_seen[i]           <= 1'b1;
                    r_bad[i]            <= !w_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scan scenarios plus random scanning
// compared every cycle against a run-length model of the scan bus.
module tb_seg_scan_decoder;

    localparam int NDIG       = 8;
    localparam int STABLE_CYC = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_i = '0;
    logic [7:0]  an_i  = '0;
    logic [31:0] value_o;
    logic [7:0]  dp_o;
    logic [7:0]  bad_mask_o;
    logic        frame_valid_o;
    logic        sel_err_o;

    seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_i         (seg_i),
        .an_i          (an_i),
        .value_o       (value_o),
        .dp_o          (dp_o),
        .bad_mask_o    (bad_mask_o),
        .frame_valid_o (frame_valid_o),
        .sel_err_o     (sel_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input int n);
        case (n)
            0: return 7'b1111110;   1: return 7'b0000110;
            2: return 7'b1101101;   3: return 7'b1111001;
            4: return 7'b0110011;   5: return 7'b1011011;
            6: return 7'b1011111;   7: return 7'b1110000;
            8: return 7'b1111111;   9: return 7'b1111011;
            10: return 7'b1110111;  11: return 7'b0011111;
            12: return 7'b0001101;  13: return 7'b0111101;
            14: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Model: a dwell is a run of identical {an,seg} samples; the run reaching STABLE_CYC
    // samples is evaluated on the following edge, and a full seen set publishes one edge later.
    logic [15:0] m_last;
    int          m_run;
    bit          m_pend;
    logic [15:0] m_pval;
    logic [7:0]  m_seen, m_bad, m_dpb;
    logic [31:0] m_nib;
    logic [31:0] e_val;
    logic [7:0]  e_dp, e_bad;
    logic        e_fv, e_sel;
    bit          m_armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_last = '0; m_run = 1; m_pend = 1'b0; m_pval = '0;
            m_seen = '0; m_bad = '0; m_dpb = '0; m_nib = '0;
            e_val = '0; e_dp = '0; e_bad = '0; e_fv = 1'b0; e_sel = 1'b0;
            m_armed = 1'b1;
        end else begin
            e_fv  = 1'b0;
            e_sel = 1'b0;
            if (m_seen == 8'hFF) begin
                e_val = m_nib; e_dp = m_dpb; e_bad = m_bad; e_fv = 1'b1;
                m_seen = '0; m_bad = '0;
            end
            if (m_pend) begin
                logic [7:0] an;
                logic [6:0] p;
                bit         hit;
                int         nib;
                an = m_pval[15:8];
                p  = m_pval[7:1];
                if ($countones(an) > 1) begin
                    e_sel = 1'b1;
                end else if (an != 0) begin
                    hit = 1'b0; nib = 0;
                    for (int k = 0; k < 16; k++)
                        if (pat(k) == p) begin hit = 1'b1; nib = k; end
                    for (int d = 0; d < NDIG; d++)
                        if (an[d]) begin
                            m_nib[4*d +: 4] = 4'(nib);
                            m_dpb[d]  = m_pval[0];
                            m_seen[d] = 1'b1;
                            m_bad[d]  = !hit;
                        end
                end
            end
            m_pend = 1'b0;
            if ({an_i, seg_i} == m_last) m_run++;
            else begin m_last = {an_i, seg_i}; m_run = 1; end
            if (m_run == STABLE_CYC) begin m_pend = 1'b1; m_pval = m_last; end
        end
    end

    int          frame_cnt = 0;
    int          sel_cnt   = 0;
    logic [31:0] f_val;
    logic [7:0]  f_dp, f_bad;

    always @(negedge clk) begin
        if (m_armed) begin
            check("value_o", value_o, e_val);
            check("dp_o", 32'(dp_o), 32'(e_dp));
            check("bad_mask_o", 32'(bad_mask_o), 32'(e_bad));
            check("frame_valid_o", 32'(frame_valid_o), 32'(e_fv));
            check("sel_err_o", 32'(sel_err_o), 32'(e_sel));
        end
        if (frame_valid_o) begin
            frame_cnt++;
            f_val = value_o; f_dp = dp_o; f_bad = bad_mask_o;
        end
        if (sel_err_o) sel_cnt++;
    end

    task automatic drive(input logic [7:0] an, input logic [7:0] seg, input int cyc);
        an_i  = an;
        seg_i = seg;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int base, input logic [31:0] v, input logic [7:0] dp,
                                input logic [7:0] bad, input string name);
        int t = 0;
        while (frame_cnt == base && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({name, "_count"}, 32'(frame_cnt), 32'(base + 1));
        check({name, "_value"}, f_val, v);
        check({name, "_dp"}, 32'(f_dp), 32'(dp));
        check({name, "_bad"}, 32'(f_bad), 32'(bad));
        drive(8'h00, 8'h00, 2);
    endtask

    task automatic check_zero(input string name);
        check({name, "_value"}, value_o, 32'h0);
        check({name, "_dp"}, 32'(dp_o), 32'h0);
        check({name, "_bad"}, 32'(bad_mask_o), 32'h0);
        check({name, "_fv"}, 32'(frame_valid_o), 32'h0);
        check({name, "_sel"}, 32'(sel_err_o), 32'h0);
    endtask

    initial begin
        int base, sbase;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 3);

        base = frame_cnt;
        for (int d = 0; d < 8; d++) drive(8'h01 << d, {pat(d + 1), 1'b0}, 6);
        expect_frame(base, 32'h87654321, 8'h00, 8'h00, "basic");

        base = frame_cnt;
        for (int d = 0; d < 3; d++) drive(8'h01 << d, {pat(d + 1), 1'b0}, 6);
        drive(8'h08, {pat(4), 1'b0}, 3);
        drive(8'h08, {pat(14), 1'b0}, 5);
        for (int d = 4; d < 8; d++) drive(8'h01 << d, {pat(d + 1), 1'b0}, 6);
        expect_frame(base, 32'h8765E321, 8'h00, 8'h00, "short_dwell");

        base = frame_cnt;
        for (int d = 0; d < 8; d++)
            drive(8'h01 << d, (d == 5) ? 8'h01 : {pat(d), 1'b0}, 6);
        expect_frame(base, 32'h76043210, 8'h20, 8'h20, "bad_glyph");

        base  = frame_cnt;
        sbase = sel_cnt;
        drive(8'h03, {pat(5), 1'b0}, 8);
        drive(8'h00, 8'h00, 4);
        check("multihot_sel_count", 32'(sel_cnt), 32'(sbase + 1));
        check("multihot_no_frame", 32'(frame_cnt), 32'(base));

        base = frame_cnt;
        drive(8'h01, {pat(0), 1'b0}, 6);
        drive(8'h02, {pat(1), 1'b0}, 6);
        drive(8'h04, {pat(9), 1'b0}, 6);
        drive(8'h04, {pat(10), 1'b0}, 6);
        for (int d = 3; d < 8; d++) drive(8'h01 << d, {pat(d), 1'b0}, 6);
        expect_frame(base, 32'h76543A10, 8'h00, 8'h00, "recapture");

        for (int d = 0; d < 5; d++) drive(8'h01 << d, {pat(9), 1'b0}, 6);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero("midframe_reset");
        base = frame_cnt;
        for (int d = 0; d < 8; d++) drive(8'h01 << d, {pat(15), 1'b0}, 6);
        expect_frame(base, 32'hFFFFFFFF, 8'h00, 8'h00, "after_reset");

        for (int n = 0; n < 160; n++) begin
            logic [7:0] an;
            logic [7:0] seg;
            int         r;
            r = $urandom_range(0, 9);
            if (r == 0) an = 8'h00;
            else if (r == 1) begin
                int a, b;
                a  = $urandom_range(0, 7);
                b  = (a + $urandom_range(1, 7)) % 8;
                an = (8'h01 << a) | (8'h01 << b);
            end else an = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
            else seg = {pat($urandom_range(0, 15)), 1'($urandom)};
            if (n == 80) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            drive(an, seg, $urandom_range(1, 7));
        end
        drive(8'h00, 8'h00, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
